// File: rtl/bcd_decade_counter_pkg.sv
// Shared BCD digit type, bounds and wrap-around successor for the decade counter.
package bcd_pkg;
  localparam int BCD_W = 4;
  typedef logic [BCD_W-1:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  // Out-of-range inputs collapse onto a legal digit so the register can never escape 0-9.
  function automatic bcd_t bcd_next(bcd_t v, logic up);
    if (up) return (v >= BCD_MAX) ? BCD_MIN : bcd_t'(v + 4'd1);
    else    return (v == BCD_MIN || v > BCD_MAX) ? BCD_MAX : bcd_t'(v - 4'd1);
  endfunction
endpackage

// File: rtl/bcd_decade_counter_tick_prescaler.sv
// Board-clock divider producing a one-cycle tick every PRESCALE_DIV enabled cycles.
module tick_prescaler #(
  parameter int PRESCALE_DIV = 12000000,
  parameter int PRESCALE_W   = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);
  localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE_DIV - 1);

  logic [PRESCALE_W-1:0] cnt;
  logic                  tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      tick_q <= 1'b0;
    end else if (sync_clr) begin
      cnt    <= '0;
      tick_q <= 1'b0;
    end else if (en) begin
      tick_q <= (cnt == LAST);
      cnt    <= (cnt == LAST) ? '0 : cnt + PRESCALE_W'(1);
    end else begin
      tick_q <= 1'b0;
    end
  end

  // Gate so a pulse registered just before en drops never leaks out while frozen.
  assign tick = tick_q & en;
endmodule

// File: rtl/bcd_decade_counter.sv
// Single BCD digit (0-9) up/down counter with load, clear and a cascadable carry/borrow.
module bcd_decade_counter
  import bcd_pkg::*;
#(
  parameter int PRESCALE_DIV = 12000000,
  parameter int PRESCALE_W   = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up_dn,
  input  logic       cin,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       tick,
  output logic       tc,
  output logic       cout
);
  bcd_t digit;
  logic step;

  tick_prescaler #(
    .PRESCALE_DIV(PRESCALE_DIV),
    .PRESCALE_W  (PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sync_clr(clear),
    .tick    (tick)
  );

  assign step = tick & en & cin;
  assign tc   = up_dn ? (digit == BCD_MAX) : (digit == BCD_MIN);
  // Derived from the current digit, so a load colliding with a wrap still signals the next digit.
  assign cout = step & tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     digit <= BCD_MIN;
    else if (clear) digit <= BCD_MIN;
    else if (load)  digit <= (load_val <= BCD_MAX) ? load_val : BCD_MIN;
    else if (step)  digit <= bcd_next(digit, up_dn);
  end

  assign {D, C, B, A} = digit;
endmodule

// File: tb/tb_bcd_decade_counter.sv
// Directed bench: prescaler timing, up/down wrap, load clamp, holds, clear, reset and a 2-digit cascade.
module tb_bcd_decade_counter;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, up_dn = 1'b1, cin = 1'b1;
  logic clear = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic A, B, C, D, tick, tc, cout;
  logic tA, tB, tC, tD, t_tick, t_tc, t_cout;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  bcd_decade_counter #(.PRESCALE_DIV(4), .PRESCALE_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .cin(cin), .clear(clear),
    .load(load), .load_val(load_val), .A(A), .B(B), .C(C), .D(D),
    .tick(tick), .tc(tc), .cout(cout));

  bcd_decade_counter #(.PRESCALE_DIV(4), .PRESCALE_W(3)) tens (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .cin(cout), .clear(clear),
    .load(load), .load_val(load_val), .A(tA), .B(tB), .C(tC), .D(tD),
    .tick(t_tick), .tc(t_tc), .cout(t_cout));

  function automatic int dig();
    return int'({D, C, B, A});
  endfunction

  function automatic int tdig();
    return int'({tD, tC, tB, tA});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc();
      seen = (tick == 1'b1);
    end
    if (!seen) chk("tick_timeout", 0, 1);
  endtask

  typedef struct {
    logic       ld;
    logic       clr;
    logic [3:0] val;
    logic       up;
    int         exp_d;
    int         exp_tc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int exp_d, cout_cnt, tick_cnt;
    int down_seq[4];
    vecs[0] = '{1'b1, 1'b0, 4'd12, 1'b1, 0, 0};
    vecs[1] = '{1'b1, 1'b0, 4'd12, 1'b0, 0, 1};
    vecs[2] = '{1'b1, 1'b0, 4'd7,  1'b1, 7, 0};
    vecs[3] = '{1'b1, 1'b0, 4'd9,  1'b1, 9, 1};
    vecs[4] = '{1'b1, 1'b0, 4'd9,  1'b0, 9, 0};
    vecs[5] = '{1'b1, 1'b0, 4'd10, 1'b1, 0, 0};
    vecs[6] = '{1'b1, 1'b0, 4'd15, 1'b0, 0, 1};
    vecs[7] = '{1'b1, 1'b1, 4'd3,  1'b1, 0, 0};
    vecs[8] = '{1'b0, 1'b0, 4'd3,  1'b1, 0, 0};
    vecs[9] = '{1'b1, 1'b0, 4'd5,  1'b1, 5, 0};
    down_seq = '{1, 0, 9, 8};

    // Reset state
    cyc(); cyc();
    chk("reset_digit", dig(), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_tens", tdig(), 0);

    // Free-running up count from release
    rst_n = 1'b1; en = 1'b1; up_dn = 1'b1; cin = 1'b1;
    cout_cnt = 0;
    for (int k = 1; k <= 44; k++) begin
      cyc();
      chk("up_tick", int'(tick), (k % 4 == 0) ? 1 : 0);
      chk("up_digit", dig(), ((k - 1) / 4) % 10);
      chk("up_cout", int'(cout), (k == 40) ? 1 : 0);
      cout_cnt += int'(cout);
    end
    chk("up_cout_count", cout_cnt, 1);

    // Tick is high with digit 0: load wins over the step, cout reflects the old digit
    load = 1'b1; load_val = 4'd2; up_dn = 1'b0;
    #1;
    chk("ld_step_tc", int'(tc), 1);
    chk("ld_step_cout", int'(cout), 1);
    cyc();
    load = 1'b0;
    chk("ld_step_digit", dig(), 2);

    // Down count 2,1,0,9,8
    exp_d = 2;
    for (int j = 0; j < 4; j++) begin
      wait_tick();
      chk("dn_tc", int'(tc), (exp_d == 0) ? 1 : 0);
      chk("dn_cout", int'(cout), (exp_d == 0) ? 1 : 0);
      cyc();
      exp_d = down_seq[j];
      chk("dn_digit", dig(), exp_d);
    end

    // Load/clear table with the counter frozen
    en = 1'b0; cin = 1'b1;
    foreach (vecs[i]) begin
      load = vecs[i].ld; clear = vecs[i].clr; load_val = vecs[i].val; up_dn = vecs[i].up;
      cyc();
      chk("tbl_digit", dig(), vecs[i].exp_d);
      chk("tbl_tc", int'(tc), vecs[i].exp_tc);
    end
    load = 1'b0; clear = 1'b0; up_dn = 1'b1;

    // Hold with en low
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("hold_en_digit", dig(), 5);
      chk("hold_en_tick", int'(tick), 0);
    end

    // Hold with cin low while the prescaler keeps running
    en = 1'b1; cin = 1'b0; tick_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("hold_cin_digit", dig(), 5);
      chk("hold_cin_cout", int'(cout), 0);
      tick_cnt += int'(tick);
    end
    chk("hold_cin_ticks", tick_cnt, 3);

    // Clear together with load restarts the prescaler
    cin = 1'b1; load = 1'b1; load_val = 4'd8;
    cyc();
    chk("pre_clr_digit", dig(), 8);
    clear = 1'b1; load_val = 4'd3;
    cyc();
    clear = 1'b0; load = 1'b0;
    chk("clr_ld_digit", dig(), 0);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("clr_tick", int'(tick), (i == 4) ? 1 : 0);
      chk("clr_digit", dig(), (i == 5) ? 1 : 0);
    end

    // Asynchronous reset mid-count
    en = 1'b0; load = 1'b1; load_val = 4'd6;
    cyc();
    load = 1'b0;
    chk("pre_rst_digit", dig(), 6);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_digit", dig(), 0);
    cyc();
    chk("rst_hold_digit", dig(), 0);
    rst_n = 1'b1; en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("rel_tick", int'(tick), (i == 4) ? 1 : 0);
      chk("rel_digit", dig(), (i == 5) ? 1 : 0);
    end

    // Two-digit cascade, 100 steps from 00
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("casc_start", tdig() * 10 + dig(), 0);
    for (int s = 1; s <= 100; s++) begin
      wait_tick();
      chk("casc_tens_tick", int'(t_tick), 1);
      chk("casc_cout", int'(cout), (((s - 1) % 10) == 9) ? 1 : 0);
      chk("casc_tens_tc", int'(t_tc), ((((s - 1) % 100) / 10) == 9) ? 1 : 0);
      chk("casc_tens_cout", int'(t_cout), (s == 100) ? 1 : 0);
      cyc();
      chk("casc_pair", tdig() * 10 + dig(), s % 100);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
